spi_tx_queue: RTL and testbench

SPI_TX_QUEUE -- requirements
Module: spi_tx_queue

---
 rtl/spi_tx_queue.sv | 116 +++++++++++
 tb/tb_spi_tx_queue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_queue.sv
// spi_tx_queue: small word FIFO that feeds an SPI master one word at a time.
// Each word gets a Start pulse, waits for SS low then high, with a busy timeout.
module spi_tx_queue #(
  parameter int BITS    = 32,
  parameter int DEPTH   = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [BITS-1:0]         InData,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic                    SS,
  output logic                    Start,
  output logic [BITS-1:0]         Data,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    Error
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL  = (AW + 1)'(DEPTH);
  localparam logic [GW-1:0] GLOAD = GW'(GAP);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t          state;
  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [GW-1:0]   gap;
  logic [TW-1:0]   tmo;
  logic            push;
  logic            pop;
  logic            tmo_hit;

  assign InReady = (Count != FULL);
  assign push    = InValid && InReady;
  // SS low on the last busy cycle wins over the timeout
  assign tmo_hit = (state == WAIT_BUSY) && SS && (tmo == TLAST);
  assign pop     = tmo_hit || ((state == WAIT_DONE) && SS);

  always_ff @(posedge Clock) begin
    if (push) mem[wptr] <= InData;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wptr  <= '0;
      rptr  <= '0;
      Count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      Start <= 1'b0;
      Data  <= '0;
      gap   <= '0;
      tmo   <= '0;
      Error <= 1'b0;
    end else begin
      Start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gap != '0) gap <= gap - 1'b1;
          if (Count != '0 && gap == '0) begin
            state <= ISSUE;
            Start <= 1'b1;
            Data  <= mem[rptr];
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
          tmo   <= '0;
        end
        WAIT_BUSY: begin
          if (!SS) begin
            state <= WAIT_DONE;
          end else if (tmo_hit) begin
            Error <= 1'b1;
            gap   <= GLOAD;
            state <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (SS) begin
            gap   <= GLOAD;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_queue.sv
// tb_spi_tx_queue: directed stimulus against a transfer-level model,
// with per-cycle output compare and literal timing pins.
module tb_spi_tx_queue;

  localparam int BITS    = 32;
  localparam int DEPTH   = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 16;

  logic            Clock = 1'b0;
  logic            Reset;
  logic [BITS-1:0] InData;
  logic            InValid;
  logic            InReady;
  logic            SS;
  logic            Start;
  logic [BITS-1:0] Data;
  logic [2:0]      Count;
  logic            Error;

  spi_tx_queue #(
    .BITS(BITS), .DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .InData(InData), .InValid(InValid), .InReady(InReady),
    .SS(SS), .Start(Start), .Data(Data),
    .Count(Count), .Error(Error)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  int edge_n = 0;

  logic [BITS-1:0] mq[$];
  bit              act;
  bit              ss_low_seen;
  int              s_edge;
  int              next_ok;
  logic [BITS-1:0] m_data;
  bit              m_err;

  int m_t0 = -1000;
  int m_len = 3;
  bit m_stuck = 0;

  logic [BITS-1:0] sd[$];
  int              se[$];

  task automatic chk(input string nm, input logic [63:0] act_v,
                     input logic [63:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h edge=%0d", nm, act_v, exp_v, edge_n);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    act = 0;
    ss_low_seen = 0;
    s_edge = -1000;
    next_ok = 0;
    m_data = '0;
    m_err = 0;
  endtask

  // transfer-level view: start when allowed, finish on SS rise or deadline
  task automatic model_edge();
    bit pushing = InValid && (mq.size() < DEPTH);
    bit popping = 0;
    bit starting = 0;
    if (act) begin
      if (edge_n > s_edge + 1) begin
        if (!ss_low_seen) begin
          if (!SS) ss_low_seen = 1;
          else if (edge_n == s_edge + 1 + TIMEOUT) begin
            popping = 1;
            m_err = 1;
          end
        end else if (SS) popping = 1;
      end
    end else if (mq.size() != 0 && edge_n >= next_ok) starting = 1;
    if (starting) begin
      act = 1;
      s_edge = edge_n;
      ss_low_seen = 0;
      m_data = mq[0];
    end
    if (popping) begin
      void'(mq.pop_front());
      act = 0;
      next_ok = edge_n + GAP + 1;
    end
    if (pushing) mq.push_back(InData);
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("start", Start, act && (s_edge == edge_n));
      chk("data", Data, m_data);
      chk("count", Count, mq.size());
      chk("inready", InReady, mq.size() != DEPTH);
      chk("error", Error, m_err);
    end
  end

  task automatic tick();
    @(posedge Clock);
    edge_n++;
    if (!Reset) model_edge();
    #1;
    if (Start) begin
      sd.push_back(Data);
      se.push_back(edge_n);
      m_t0 = edge_n;
    end
    SS = m_stuck ? 1'b1
       : !((edge_n - m_t0) >= 1 && (edge_n - m_t0) <= m_len);
  endtask

  task automatic push1(input logic [BITS-1:0] w);
    InData = w;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
  endtask

  task automatic wait_empty(input int bound, output int pe);
    pe = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (Count == 0) begin
        pe = edge_n;
        break;
      end
    end
    if (pe < 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout count=%0d want=0", Count);
    end
  endtask

  task automatic chk_seq(input string nm, input logic [BITS-1:0] exp[$]);
    chk({nm, "_n"}, sd.size(), exp.size());
    for (int i = 0; i < exp.size() && i < sd.size(); i++)
      chk(nm, sd[i], exp[i]);
  endtask

  int k;
  int pe;
  int ee;

  initial begin
    Reset = 1'b1;
    InValid = 1'b0;
    InData = '0;
    SS = 1'b1;
    model_reset();
    tick();
    tick();
    chk("rst_count", Count, 0);
    chk("rst_ready", InReady, 1);
    chk("rst_start", Start, 0);
    chk("rst_data", Data, 0);
    chk("rst_err", Error, 0);
    Reset = 1'b0;
    chk_en = 1;

    // single word, SS low for 34 cycles
    m_len = 34;
    sd.delete(); se.delete();
    push1(32'hDEADBEEF);
    k = edge_n;
    chk("t1_cnt1", Count, 1);
    chk("t1_nostart", Start, 0);
    tick();
    chk("t1_start", Start, 1);
    chk("t1_data", Data, 32'hDEADBEEF);
    wait_empty(100, pe);
    chk("t1_pop_edge", pe - k, 37);
    chk("t1_pulses", se.size(), 1);
    chk("t1_held", Data, 32'hDEADBEEF);
    repeat (5) tick();

    // fill to full, offer one more
    m_len = 3;
    sd.delete(); se.delete();
    for (int i = 1; i <= 4; i++) begin
      InData = i;
      InValid = 1'b1;
      tick();
    end
    chk("t2_full_ready", InReady, 0);
    chk("t2_full_cnt", Count, 4);
    InData = 5;
    tick();
    InValid = 1'b0;
    chk("t2_refused", Count, 4);
    wait_empty(200, pe);
    chk_seq("t2_order", '{32'h1, 32'h2, 32'h3, 32'h4});
    for (int i = 1; i < se.size(); i++)
      chk("t2_spacing", se[i] - se[i-1], 5 + GAP + 1);
    repeat (5) tick();

    // master never answers
    m_stuck = 1;
    sd.delete(); se.delete();
    push1(32'hA5A5A5A5);
    k = edge_n;
    ee = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (Error) begin
        ee = edge_n;
        break;
      end
    end
    chk("t3_err_edge", ee - k, TIMEOUT + 2);
    chk("t3_cnt", Count, 0);
    chk("t3_data", Data, 32'hA5A5A5A5);
    m_stuck = 0;
    repeat (5) tick();
    push1(32'h11);
    wait_empty(100, pe);
    chk_seq("t3_order", '{32'hA5A5A5A5, 32'h11});
    chk("t3_sticky", Error, 1);
    repeat (5) tick();

    // push on the pop edge while full
    m_len = 3;
    sd.delete(); se.delete();
    for (int i = 0; i < 4; i++) push1(32'h21 + i);
    InData = 32'h77;
    InValid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (Count == 3) break;
    end
    chk("t4_cnt3", Count, 3);
    tick();
    InValid = 1'b0;
    chk("t4_accept", Count, 4);
    wait_empty(200, pe);
    chk_seq("t4_order", '{32'h21, 32'h22, 32'h23, 32'h24, 32'h77});
    repeat (5) tick();

    // pushes while the master is busy
    m_len = 10;
    sd.delete(); se.delete();
    push1(32'h31);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      push1(32'h32 + i);
      chk("t5_cnt", Count, 2 + i);
      chk("t5_data", Data, 32'h31);
    end
    tick();
    chk("t5_hold", Data, 32'h31);
    wait_empty(200, pe);
    chk_seq("t5_order", '{32'h31, 32'h32, 32'h33, 32'h34});
    repeat (5) tick();

    // reset in the middle of a transfer
    m_len = 20;
    sd.delete(); se.delete();
    for (int i = 0; i < 3; i++) push1(32'h41 + i);
    tick();
    tick();
    chk("t6_pre_cnt", Count, 3);
    chk("t6_pre_err", Error, 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("t6_start", Start, 0);
    chk("t6_cnt", Count, 0);
    chk("t6_err", Error, 0);
    chk("t6_ready", InReady, 1);
    model_reset();
    m_t0 = -1000;
    tick();
    tick();
    Reset = 1'b0;
    se.delete(); sd.delete();
    repeat (30) tick();
    chk("t6_nostart", se.size(), 0);
    push1(32'h99);
    chk("t6_post", Count, 1);
    wait_empty(100, pe);
    chk_seq("t6_order", '{32'h99});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
